// File: rtl/axi_rom_rd_ctrl.sv
// AXI4 read-only slave front-end for a 1-cycle-latency synchronous ROM.
// Ports: AR/R AXI4 read channels; rom_addr/rom_rd_en/rom_rdata ROM side.
module axi_rom_rd_ctrl #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 128,
    parameter int ID_WD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arvalid,
    output logic               arready,
    input  logic [ID_WD-1:0]   arid,
    input  logic [ADDR_WD-1:0] araddr,
    input  logic [7:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    output logic               rvalid,
    input  logic               rready,
    output logic [ID_WD-1:0]   rid,
    output logic [DATA_WD-1:0] rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic [ADDR_WD-1:0] rom_addr,
    output logic               rom_rd_en,
    input  logic [DATA_WD-1:0] rom_rdata
);

    localparam int WSH = $clog2(DATA_WD / 8);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [ID_WD-1:0]   id_q, id_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [2:0]         size_q, size_d;
    logic [1:0]         burst_q, burst_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADDR_WD-1:0] rom_addr_q, rom_addr_d;

    // Tag of the read currently inside the ROM pipeline register.
    logic               infl_q, infl_d;
    logic [ID_WD-1:0]   infl_id_q, infl_id_d;
    logic               infl_last_q, infl_last_d;

    // 2-entry response FIFO.
    logic [DATA_WD-1:0] fd_q [2];
    logic [DATA_WD-1:0] fd_d [2];
    logic [ID_WD-1:0]   fid_q [2];
    logic [ID_WD-1:0]   fid_d [2];
    logic [1:0]         flast_q, flast_d;
    logic               wp_q, wp_d;
    logic               rp_q, rp_d;
    logic [1:0]         fcnt_q, fcnt_d;

    logic               pop;
    logic               issue;
    logic               last_beat;
    logic [2:0]         credit;
    logic [ADDR_WD-1:0] step;
    logic [ADDR_WD-1:0] wmask;
    logic [ADDR_WD-1:0] next_addr;
    logic               wrap_ok;

    assign rvalid = (fcnt_q != 2'd0);
    assign rdata  = fd_q[rp_q];
    assign rid    = rvalid ? fid_q[rp_q] : '0;
    assign rlast  = rvalid & flast_q[rp_q];
    assign rresp  = 2'b00;

    always_comb begin
        step      = ADDR_WD'(1) << size_q;
        wmask     = ((ADDR_WD'(len_q) + ADDR_WD'(1)) << size_q) - ADDR_WD'(1);
        wrap_ok   = len_q inside {8'd1, 8'd3, 8'd7, 8'd15};
        next_addr = (addr_q & ~(step - ADDR_WD'(1))) + step;
        unique case (burst_q)
            2'd0:    next_addr = addr_q;
            2'd2:    if (wrap_ok)
                         next_addr = (addr_q & ~wmask) | ((addr_q + step) & wmask);
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        infl_d      = 1'b0;
        infl_id_d   = infl_id_q;
        infl_last_d = infl_last_q;
        fd_d        = fd_q;
        fid_d       = fid_q;
        flast_d     = flast_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        arready     = 1'b0;
        rom_rd_en   = 1'b0;

        pop       = rvalid & rready;
        last_beat = (cnt_q == len_q);
        // Credit counts buffered beats plus the read still in the ROM.
        credit    = 3'(fcnt_q) + 3'(infl_q) - 3'(pop);
        issue     = (state_q == BURST) && (credit < 3'd2);

        unique case (state_q)
            IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    size_d  = arsize;
                    burst_d = arburst;
                    cnt_d   = 8'd0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    rom_rd_en   = 1'b1;
                    infl_d      = 1'b1;
                    infl_id_d   = id_q;
                    infl_last_d = last_beat;
                    cnt_d       = cnt_q + 8'd1;
                    addr_d      = next_addr;
                    if (last_beat)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rom_addr   = rom_rd_en ? (addr_q >> WSH) : rom_addr_q;
        rom_addr_d = rom_addr;

        if (infl_q) begin
            fd_d[wp_q]    = rom_rdata;
            fid_d[wp_q]   = infl_id_q;
            flast_d[wp_q] = infl_last_q;
            wp_d          = ~wp_q;
        end
        if (pop)
            rp_d = ~rp_q;
        fcnt_d = fcnt_q + 2'(infl_q) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            infl_q      <= 1'b0;
            infl_id_q   <= '0;
            infl_last_q <= 1'b0;
            flast_q     <= '0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            infl_q      <= infl_d;
            infl_id_q   <= infl_id_d;
            infl_last_q <= infl_last_d;
            flast_q     <= flast_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Payload storage needs no reset; rvalid qualifies it.
    always_ff @(posedge clk) begin
        fd_q  <= fd_d;
        fid_q <= fid_d;
    end

endmodule
